mipi_csi_rx_packet_decoder_8b2lane: RTL and testbench
=====================================================

# mipi_csi_rx_packet_decoder_8b2lane

Parses the byte-aligned 2-lane MIPI CSI-2 stream from the lane aligner. It decodes the 4-byte packet header, filters by virtual channel and data type, and forwards the RAW10/12/14 long-packet payload to the RAW depacker as 16-bit words. Alongside the payload it supplies a stable 3-bit packet type, and it emits frame start/end pulses from short packets. It sits directly between the lane aligner and `mipi_csi_rx_raw_depacker_8b2lane`.

## Interface
- `VIRTUAL_CHANNEL`, default 2'd0: only packets with DI[7:6] equal to this value are processed.
- `clk_i` input 1: byte clock, shared with the depacker. Single clock domain.
- `reset_n_i` input 1: reset, synchronous, active-low.
- `data_valid_i` input 1: aligned lane data valid. Low between packets (LP/EoT).
- `data_i` input 16: lane0 byte in [7:0], lane1 byte in [15:8]. [7:0] is the earlier byte on the wire.
- `output_valid_o` output 1: payload word valid.
- `data_o` output 16: payload word, same byte order as input.
- `packet_type_o` output 3: DI[2:0] of the current long packet. 3 = RAW10, 4 = RAW12, 5 = RAW14.
- `frame_start_o` output 1: one-cycle pulse on a Frame Start short packet (DT 0x00).
- `frame_end_o` output 1: one-cycle pulse on a Frame End short packet (DT 0x01).

## Operation
- Header layout: first valid cycle H0 = {WC[7:0], DI}; second valid cycle H1 = {ECC, WC[15:8]}. ECC is not checked or corrected.
- State IDLE:
  - On a rising data_valid_i, capture H0 and go to HDR1.
- State HDR1: assemble WC[15:0] and classify the packet.
  - VC mismatch -> DRAIN.
  - DT 0x00 or 0x01 -> pulse frame_start_o or frame_end_o, then DRAIN. The pulse is issued only on a VC match.
  - Other short packets (DT 0x02–0x0F) -> DRAIN.
  - DT 0x2B, 0x2C, 0x2D with WC != 0 -> load word counter with ceil(WC/2), latch packet_type_o = DI[2:0], go to PAYLOAD.
  - Any other DT, or WC == 0 -> DRAIN with no output.
- State PAYLOAD:
  - Each valid cycle: register data_i to data_o, assert output_valid_o, decrement counter.
  - When the counter reaches 0 -> DRAIN.
  - Odd WC: on the last word, data_o[15:8] is forced to 8'h00.
- State DRAIN: ignore input (packet footer, trailing bytes) until data_valid_i is low, then go to IDLE.
- data_valid_i low in any state -> IDLE on the next edge. output_valid_o deasserts in that cycle. The partial line is truncated with no error flag.
- packet_type_o holds its value until the next accepted RAW long-packet header. It never changes while output_valid_o is high.
- Word counter is 15 bits and covers WC up to 65535. No wrap-around is possible.

## Timing
- Reset (reset_n_i low at an edge):
  - State = IDLE.
  - output_valid_o = 0, data_o = 0, packet_type_o = 3'd3 (RAW10), frame_start_o = 0, frame_end_o = 0.
  - Reset takes priority over every other event, including reset asserted mid-payload.
- H0 sampled at edge n, H1 at edge n+1.
- packet_type_o is updated at edge n+2. This is at least one cycle before output_valid_o rises, so the depacker latches it while its own valid input is low.
- First payload word is sampled at edge n+2 and presented with output_valid_o = 1 after edge n+3. Fixed latency: 1 cycle from input to output.
- output_valid_o is high for exactly ceil(WC/2) consecutive cycles when data_valid_i stays high, with no gaps.
- frame_start_o / frame_end_o are high for the single cycle after edge n+2.
- If data_valid_i drops in the same cycle the counter reaches 0, the last word is still output and the state goes to IDLE.
- Back-to-back packets: data_valid_i must be low for at least 1 cycle between packets. This rule applies to the whole upstream chain.

## Test plan
- RAW10 line, VC0: H0 = 16'h0A2B, H1 = {ECC, 8'h00}, then payload 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09 -> output_valid_o high for 5 cycles starting at n+3. data_o carries the same 5 words in order. packet_type_o = 3 from n+2.
- Frame Start short packet: H0 = 16'h0000, H1 = 16'hXX00 -> frame_start_o single pulse after edge n+2. output_valid_o stays 0. Repeat with DT 0x01 -> frame_end_o pulse.
- Filtering:
  - DT 0x1E (YUV422), WC = 8 -> no output_valid_o, packet_type_o unchanged.
  - DI = 8'h6B (VC1, RAW10) with VIRTUAL_CHANNEL = 0 -> no output.
  - WC = 0 RAW12 -> no output.
- Odd WC: RAW12, WC = 5, payload 16'hBBAA, 16'hDDCC, 16'h11EE -> 3 output words. The last is 16'h00EE.
- Truncation: RAW14, WC = 100, data_valid_i drops after 10 payload words -> exactly 10 output words, state IDLE. The next packet decodes normally.
- Reset mid-payload: reset_n_i low for 1 cycle during PAYLOAD -> all outputs at reset values after the next edge. Payload continuing on data_i is ignored until a new header follows a data_valid_i low period.

Source files
------------

// File: rtl/mipi_csi_rx_packet_decoder_8b2lane.sv
// CSI-2 2-lane packet decoder: parses the 4-byte header and filters by VC/DT.
// Forwards RAW10/12/14 payload as 16-bit words, and pulses frame start/end on short packets.
module mipi_csi_rx_packet_decoder_8b2lane #(
  parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        data_valid_i,
  input  logic [15:0] data_i,
  output logic        output_valid_o,
  output logic [15:0] data_o,
  output logic [2:0]  packet_type_o,
  output logic        frame_start_o,
  output logic        frame_end_o
);

  typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        in_valid_q, in_valid_d1_q;
  logic [15:0] in_data_q;
  logic [15:0] hdr0_q, hdr0_d;
  logic [14:0] cnt_q, cnt_d;
  logic        odd_q, odd_d;
  logic        ov_q, ov_d;
  logic [15:0] dout_q, dout_d;
  logic [2:0]  ptype_q, ptype_d;
  logic        fs_q, fs_d;
  logic        fe_q, fe_d;

  logic [15:0] wc;
  logic [15:0] wc_m1;
  logic [7:0]  di;
  logic [5:0]  dt;
  logic        is_raw;
  logic        last_word;

  assign di        = hdr0_q[7:0];
  assign dt        = di[5:0];
  assign wc        = {in_data_q[7:0], hdr0_q[15:8]};
  assign wc_m1     = wc - 16'd1;
  assign is_raw    = (dt == 6'h2B) || (dt == 6'h2C) || (dt == 6'h2D);
  assign last_word = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    hdr0_d  = hdr0_q;
    cnt_d   = cnt_q;
    odd_d   = odd_q;
    ov_d    = 1'b0;
    dout_d  = dout_q;
    ptype_d = ptype_q;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_q && !in_valid_d1_q) begin
          hdr0_d  = in_data_q;
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (!in_valid_q) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
          if (di[7:6] == VIRTUAL_CHANNEL) begin
            fs_d = (dt == 6'h00);
            fe_d = (dt == 6'h01);
            if (is_raw && (wc != '0)) begin
              // Counter holds words-remaining minus one so WC=65535 fits in 15 bits.
              cnt_d   = wc_m1[15:1];
              odd_d   = wc[0];
              ptype_d = di[2:0];
              state_d = PAYLOAD;
            end
          end
        end
      end
      PAYLOAD: begin
        if (!in_valid_q) begin
          state_d = IDLE;
        end else begin
          ov_d   = 1'b1;
          dout_d = (last_word && odd_q) ? {8'h00, in_data_q[7:0]} : in_data_q;
          if (last_word) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q - 15'd1;
          end
        end
      end
      DRAIN: begin
        if (!in_valid_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      // Valid history resets high so a packet still streaming through reset is not taken as a new header.
      in_valid_q    <= 1'b1;
      in_valid_d1_q <= 1'b1;
      in_data_q     <= '0;
      hdr0_q        <= '0;
      cnt_q         <= '0;
      odd_q         <= 1'b0;
      ov_q          <= 1'b0;
      dout_q        <= '0;
      ptype_q       <= 3'd3;
      fs_q          <= 1'b0;
      fe_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_valid_q    <= data_valid_i;
      in_valid_d1_q <= in_valid_q;
      in_data_q     <= data_i;
      hdr0_q        <= hdr0_d;
      cnt_q         <= cnt_d;
      odd_q         <= odd_d;
      ov_q          <= ov_d;
      dout_q        <= dout_d;
      ptype_q       <= ptype_d;
      fs_q          <= fs_d;
      fe_q          <= fe_d;
    end
  end

  assign output_valid_o = ov_q;
  assign data_o         = dout_q;
  assign packet_type_o  = ptype_q;
  assign frame_start_o  = fs_q;
  assign frame_end_o    = fe_q;

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_8b2lane.sv
// Directed bench for the CSI-2 packet decoder.
// Expected payload words are queued at stimulus time and popped as the DUT emits them.
module tb_mipi_csi_rx_packet_decoder_8b2lane;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        data_valid_i;
  logic [15:0] data_i;
  logic        output_valid_o;
  logic [15:0] data_o;
  logic [2:0]  packet_type_o;
  logic        frame_start_o;
  logic        frame_end_o;

  always #5 clk_i = ~clk_i;

  mipi_csi_rx_packet_decoder_8b2lane #(.VIRTUAL_CHANNEL(2'd0)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .data_valid_i   (data_valid_i),
    .data_i         (data_i),
    .output_valid_o (output_valid_o),
    .data_o         (data_o),
    .packet_type_o  (packet_type_o),
    .frame_start_o  (frame_start_o),
    .frame_end_o    (frame_end_o)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  ptype;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] pay[$];
  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int h0_at = 0;
  int first_ov_at = -1;
  int ov_cnt = 0;
  int fs_cnt = 0;
  int fe_cnt = 0;
  int fs_at = 0;
  int fe_at = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [2:0] t);
    exp_t e;
    e.data  = d;
    e.ptype = t;
    sb.push_back(e);
  endtask

  // One clock: drive inputs, sample outputs 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [15:0] d);
    exp_t e;
    data_valid_i = v;
    data_i       = d;
    @(posedge clk_i);
    #1;
    cyc_n++;
    if (output_valid_o) begin
      ov_cnt++;
      if (first_ov_at < 0) first_ov_at = cyc_n;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_word: observed %0h expected no output", data_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data_o", {16'h0, data_o}, {16'h0, e.data});
        chk("packet_type_o", {29'h0, packet_type_o}, {29'h0, e.ptype});
      end
    end
    if (frame_start_o) begin fs_cnt++; fs_at = cyc_n; end
    if (frame_end_o)   begin fe_cnt++; fe_at = cyc_n; end
  endtask

  task automatic send(input logic [7:0] di, input logic [15:0] wc, input bit footer);
    first_ov_at = -1;
    ov_cnt      = 0;
    cyc(1'b1, {wc[7:0], di});
    h0_at = cyc_n;
    cyc(1'b1, {8'h5A, wc[15:8]});
    while (pay.size() > 0) cyc(1'b1, pay.pop_front());
    if (footer) cyc(1'b1, 16'hC3C3);
    repeat (4) cyc(1'b0, 16'h0000);
  endtask

  initial begin
    reset_n_i    = 1'b0;
    data_valid_i = 1'b0;
    data_i       = '0;
    repeat (2) cyc(1'b0, 16'h0000);
    chk("rst_output_valid", {31'h0, output_valid_o}, 32'h0);
    chk("rst_data_o", {16'h0, data_o}, 32'h0);
    chk("rst_packet_type", {29'h0, packet_type_o}, 32'h3);
    chk("rst_fs_fe", {30'h0, frame_start_o, frame_end_o}, 32'h0);
    reset_n_i = 1'b1;
    repeat (3) cyc(1'b0, 16'h0000);

    // RAW10 line, WC=10 -> 5 words.
    for (int unsigned i = 0; i < 5; i++) begin
      pay.push_back(16'((2*i+2) << 8 | (2*i+1)));
      push_exp(16'((2*i+2) << 8 | (2*i+1)), 3'd3);
    end
    send(8'h2B, 16'd10, 1'b1);
    chk("raw10_count", ov_cnt, 5);
    chk("raw10_latency", first_ov_at - h0_at, 3);
    chk("raw10_sb_empty", sb.size(), 0);

    // Frame start / frame end short packets.
    send(8'h00, 16'h0000, 1'b0);
    chk("fs_count", fs_cnt, 1);
    chk("fs_timing", fs_at - h0_at, 2);
    chk("fs_no_output", ov_cnt, 0);
    send(8'h01, 16'h0000, 1'b0);
    chk("fe_count", fe_cnt, 1);
    chk("fe_timing", fe_at - h0_at, 2);
    chk("fe_no_fs", fs_cnt, 1);

    // Filtering: YUV422, wrong VC, VC1 frame start, WC=0 RAW12.
    repeat (4) pay.push_back(16'h1234);
    send(8'h1E, 16'd8, 1'b1);
    chk("yuv_no_output", ov_cnt, 0);
    chk("yuv_ptype_kept", {29'h0, packet_type_o}, 32'h3);
    repeat (5) pay.push_back(16'h5678);
    send(8'h6B, 16'd10, 1'b1);
    chk("vc1_no_output", ov_cnt, 0);
    send(8'h40, 16'h0000, 1'b0);
    chk("vc1_fs_blocked", fs_cnt, 1);
    send(8'h2C, 16'd0, 1'b1);
    chk("wc0_no_output", ov_cnt, 0);
    chk("wc0_ptype_kept", {29'h0, packet_type_o}, 32'h3);

    // Odd WC RAW12, with packet_type timing checked per edge.
    first_ov_at = -1;
    ov_cnt      = 0;
    push_exp(16'hBBAA, 3'd4);
    push_exp(16'hDDCC, 3'd4);
    push_exp(16'h00EE, 3'd4);
    cyc(1'b1, 16'h052C);
    h0_at = cyc_n;
    cyc(1'b1, 16'h5A00);
    chk("odd_ptype_n1", {29'h0, packet_type_o}, 32'h3);
    cyc(1'b1, 16'hBBAA);
    chk("odd_ptype_n2", {29'h0, packet_type_o}, 32'h4);
    chk("odd_valid_n2", {31'h0, output_valid_o}, 32'h0);
    cyc(1'b1, 16'hDDCC);
    cyc(1'b1, 16'h11EE);
    cyc(1'b1, 16'hC3C3);
    repeat (4) cyc(1'b0, 16'h0000);
    chk("odd_count", ov_cnt, 3);
    chk("odd_latency", first_ov_at - h0_at, 3);
    chk("odd_sb_empty", sb.size(), 0);

    // Truncation: RAW14 WC=100, valid drops after 10 words.
    for (int unsigned i = 0; i < 10; i++) begin
      pay.push_back(16'(16'hA000 + i));
      push_exp(16'(16'hA000 + i), 3'd5);
    end
    send(8'h2D, 16'd100, 1'b0);
    chk("trunc_count", ov_cnt, 10);
    chk("trunc_sb_empty", sb.size(), 0);
    pay.push_back(16'h4321);
    pay.push_back(16'h8765);
    push_exp(16'h4321, 3'd3);
    push_exp(16'h8765, 3'd3);
    send(8'h2B, 16'd4, 1'b1);
    chk("post_trunc_count", ov_cnt, 2);
    chk("post_trunc_sb_empty", sb.size(), 0);

    // Reset mid-payload on RAW12.
    first_ov_at = -1;
    ov_cnt      = 0;
    push_exp(16'h7000, 3'd4);
    push_exp(16'h7001, 3'd4);
    cyc(1'b1, 16'h142C);
    cyc(1'b1, 16'h5A00);
    cyc(1'b1, 16'h7000);
    cyc(1'b1, 16'h7001);
    cyc(1'b1, 16'h7002);
    reset_n_i = 1'b0;
    cyc(1'b1, 16'h7003);
    reset_n_i = 1'b1;
    chk("midrst_output_valid", {31'h0, output_valid_o}, 32'h0);
    chk("midrst_data_o", {16'h0, data_o}, 32'h0);
    chk("midrst_packet_type", {29'h0, packet_type_o}, 32'h3);
    chk("midrst_fs_fe", {30'h0, frame_start_o, frame_end_o}, 32'h0);
    for (int unsigned i = 4; i < 8; i++) cyc(1'b1, 16'(16'h7000 + i));
    repeat (3) cyc(1'b0, 16'h0000);
    chk("midrst_count", ov_cnt, 2);
    chk("midrst_sb_empty", sb.size(), 0);
    pay.push_back(16'h9ABC);
    pay.push_back(16'hDEF0);
    push_exp(16'h9ABC, 3'd4);
    push_exp(16'hDEF0, 3'd4);
    send(8'h2C, 16'd4, 1'b1);
    chk("post_rst_count", ov_cnt, 2);
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
